qdr_init_sequencer: RTL and testbench
=====================================

QDR_INIT_SEQUENCER -- requirements
Module: qdr_init_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PLL_STABLE, 256, consecutive synchronised-lock cycles required before SRAM DLL enable.
- DOFF_WAIT, 2048, cycles qdr_doffn is held high before calibration starts (SRAM DLL settle).
- CAL_TIMEOUT, 65536, cycles allowed per calibration attempt.
- MAX_RETRY, 3, calibration retries after the first attempt.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, qdr_clk_0 from the QDR clock infrastructure; the only clock.
- reset, in, 1, synchronous, active-high.
- pll_lock, in, 1, PLL lock from the QDR clock infrastructure; asynchronous to clk.
- cal_done, in, 1, single-cycle pulse from the PHY calibration engine: success.
- cal_fail, in, 1, single-cycle pulse from the PHY calibration engine: failure.
- qdr_doffn, out, 1, QDR SRAM DLL enable (low means DLL off).
- ctrl_reset, out, 1, active-high reset to the QDR controller/PHY.
- cal_start, out, 1, single-cycle calibration start pulse.
- phy_ready, out, 1, high while the interface is calibrated and usable.
- init_fail, out, 1, sticky failure flag.
- retry_count, out, 2, number of calibration retries used.

REQ-003 One clock; reset is synchronous and active-high.

Function
REQ-004 pll_lock SHALL pass through a 2-flop synchroniser (lock_s); all decisions SHALL use lock_s only. Synchroniser flops SHALL reset to 0.
REQ-005 The FSM SHALL have states IDLE, LOCK_WAIT, DOFF, CAL, CAL_RETRY, READY and FAIL.
REQ-006 IDLE SHALL go to LOCK_WAIT when lock_s=1; the stable counter SHALL clear on entry.
REQ-007 LOCK_WAIT SHALL increment the stable counter each cycle lock_s=1, and SHALL go to DOFF on the cycle the counter reaches PLL_STABLE-1.
REQ-008 DOFF SHALL count DOFF_WAIT cycles (counter cleared on entry), then go to CAL.
REQ-009 On entering CAL, the timeout counter SHALL clear and cal_start SHALL pulse high for exactly the first CAL cycle.
REQ-010 In CAL, the following transitions SHALL apply:
- cal_done=1 goes to READY.
- cal_fail=1 or timeout counter = CAL_TIMEOUT-1 goes to CAL_RETRY if retry_count<MAX_RETRY, else to FAIL.
- cal_done and cal_fail high in the same cycle SHALL be treated as fail.
- cal_done/cal_fail on the cal_start cycle SHALL be honoured.
REQ-011 CAL_RETRY SHALL last exactly one cycle, increment retry_count (saturating at 3), then return to CAL.
REQ-012 lock_s=0 in LOCK_WAIT, DOFF, CAL, CAL_RETRY or READY SHALL force IDLE on the next cycle and clear retry_count. Lock loss SHALL take priority over all other transitions that cycle.
REQ-013 FAIL SHALL be terminal until reset; lock loss SHALL be ignored in FAIL.
REQ-014 All outputs SHALL be registered and decoded from the next state, so they change on the same edge as the state register.
REQ-015 qdr_doffn SHALL be 1 in DOFF, CAL, CAL_RETRY and READY, and 0 in IDLE, LOCK_WAIT and FAIL.
REQ-016 ctrl_reset SHALL be 0 only in CAL and READY, and 1 otherwise, including CAL_RETRY.
REQ-017 phy_ready SHALL be 1 only in READY.
REQ-018 init_fail SHALL be 1 only in FAIL.
REQ-019 Counters SHALL be sized to hold the maximum parameter value, using clog2 of max(PLL_STABLE, DOFF_WAIT, CAL_TIMEOUT) bits. Counters SHALL not wrap within a state.

Reset
REQ-020 While reset=1, the following SHALL hold on every clk edge:
- state=IDLE and all counters=0.
- qdr_doffn=0, ctrl_reset=1, cal_start=0, phy_ready=0, init_fail=0, retry_count=0.
REQ-021 Reset asserted in any state, including FAIL and mid-calibration, SHALL produce the REQ-020 values on the next edge.

Verification
REQ-022 Nominal: small parameters (PLL_STABLE=4, DOFF_WAIT=8, CAL_TIMEOUT=16, MAX_RETRY=3). Release reset; pll_lock=1 at cycle 0 gives:
- qdr_doffn rises at cycle 2+4 (±1).
- cal_start pulses 8 cycles later.
- cal_done 3 cycles after cal_start gives phy_ready=1 and ctrl_reset=0 on the next edge.
REQ-023 Retry: three cal_fail pulses, then cal_done, gives three cal_start re-pulses, retry_count=3, then phy_ready=1 and init_fail=0.
REQ-024 Exhaustion: cal_fail on every attempt gives 4 cal_start pulses, then init_fail=1, qdr_doffn=0, ctrl_reset=1. A later lock drop leaves FAIL unchanged.
REQ-025 Timeout: no cal_done/cal_fail gives a retry every 16 cycles, then FAIL after the fourth attempt.
REQ-026 Lock loss: drop pll_lock in READY gives phy_ready=0, qdr_doffn=0, ctrl_reset=1 within 3 cycles and retry_count=0. Relock gives a full resequence from LOCK_WAIT.
REQ-027 Glitch and collision cases:
- pll_lock low for 1 cycle during LOCK_WAIT restarts the stable count.
- cal_done and cal_fail high together count as a fail (retry_count increments).
- reset mid-CAL gives REQ-020 values next edge.

Source files
------------

// File: rtl/qdr_init_sequencer.sv
// QDR SRAM power-up / calibration sequencer.
// Waits for a stable PLL lock, enables the SRAM DLL and lets it settle.
// It then runs PHY calibration with a bounded number of retries and
// reports either a calibrated interface or a sticky failure.
module qdr_init_sequencer #(
    parameter int PLL_STABLE  = 256,
    parameter int DOFF_WAIT   = 2048,
    parameter int CAL_TIMEOUT = 65536,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       cal_done,
    input  logic       cal_fail,
    output logic       qdr_doffn,
    output logic       ctrl_reset,
    output logic       cal_start,
    output logic       phy_ready,
    output logic       init_fail,
    output logic [1:0] retry_count
);

    // One counter width covers the longest wait, so no counter can wrap
    // before its state exits.
    localparam int MAX_A   = (PLL_STABLE > DOFF_WAIT) ? PLL_STABLE : DOFF_WAIT;
    localparam int MAX_CNT = (MAX_A > CAL_TIMEOUT) ? MAX_A : CAL_TIMEOUT;
    localparam int CW      = ($clog2(MAX_CNT) < 1) ? 1 : $clog2(MAX_CNT);

    localparam logic [CW-1:0] STABLE_LAST  = CW'(PLL_STABLE - 1);
    localparam logic [CW-1:0] DOFF_LAST    = CW'(DOFF_WAIT - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(CAL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOCK_WAIT,
        DOFF,
        CAL,
        CAL_RETRY,
        READY,
        FAIL
    } state_t;

    state_t state;
    state_t next_state;

    logic          lock_meta;
    logic          lock_s;
    logic [CW-1:0] stable_cnt;
    logic [CW-1:0] doff_cnt;
    logic [CW-1:0] timeout_cnt;
    logic          attempt_failed;
    logic          can_retry;

    // A simultaneous done/fail counts as a failure, as does an expired attempt.
    assign attempt_failed = cal_fail | (timeout_cnt == TIMEOUT_LAST);
    assign can_retry      = (int'(retry_count) < MAX_RETRY);

    // Bring the asynchronous PLL lock into the clk domain through two flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; loss of lock beats everything except the terminal FAIL.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (lock_s) begin
                    next_state = LOCK_WAIT;
                end
            end
            LOCK_WAIT: begin
                if (!lock_s) begin
                    next_state = IDLE;
                end else if (stable_cnt == STABLE_LAST) begin
                    next_state = DOFF;
                end
            end
            DOFF: begin
                if (!lock_s) begin
                    next_state = IDLE;
                end else if (doff_cnt == DOFF_LAST) begin
                    next_state = CAL;
                end
            end
            CAL: begin
                if (!lock_s) begin
                    next_state = IDLE;
                end else if (attempt_failed) begin
                    next_state = can_retry ? CAL_RETRY : FAIL;
                end else if (cal_done) begin
                    next_state = READY;
                end
            end
            CAL_RETRY: begin
                next_state = lock_s ? CAL : IDLE;
            end
            READY: begin
                if (!lock_s) begin
                    next_state = IDLE;
                end
            end
            FAIL: begin
                next_state = FAIL;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Per-state wait counters: run while the state holds, clear on any change.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_cnt  <= '0;
            doff_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            stable_cnt  <= (state == LOCK_WAIT && next_state == LOCK_WAIT) ?
                           stable_cnt + CW'(1) : '0;
            doff_cnt    <= (state == DOFF && next_state == DOFF) ?
                           doff_cnt + CW'(1) : '0;
            timeout_cnt <= (state == CAL && next_state == CAL) ?
                           timeout_cnt + CW'(1) : '0;
        end
    end

    // Retry counter steps as CAL_RETRY is entered and clears whenever we fall back to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            retry_count <= 2'd0;
        end else if (next_state == IDLE) begin
            retry_count <= 2'd0;
        end else if (state == CAL && next_state == CAL_RETRY &&
                     retry_count != 2'd3) begin
            retry_count <= retry_count + 2'd1;
        end
    end

    // Registered outputs decoded from the next state so they align with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            qdr_doffn  <= 1'b0;
            ctrl_reset <= 1'b1;
            cal_start  <= 1'b0;
            phy_ready  <= 1'b0;
            init_fail  <= 1'b0;
        end else begin
            qdr_doffn  <= (next_state == DOFF) || (next_state == CAL) ||
                          (next_state == CAL_RETRY) || (next_state == READY);
            ctrl_reset <= !((next_state == CAL) || (next_state == READY));
            cal_start  <= (next_state == CAL) && (state != CAL);
            phy_ready  <= (next_state == READY);
            init_fail  <= (next_state == FAIL);
        end
    end

endmodule

// File: tb/tb_qdr_init_sequencer.sv
// Self-checking bench for qdr_init_sequencer.
// A phase/age reference model predicts every output on every cycle.
// Directed scenarios and a randomized run drive both the model and the DUT.
module tb_qdr_init_sequencer;

    localparam int PS = 4;
    localparam int DW = 8;
    localparam int CT = 16;
    localparam int MR = 3;

    localparam int P_IDLE  = 0;
    localparam int P_LW    = 1;
    localparam int P_DOFF  = 2;
    localparam int P_CAL   = 3;
    localparam int P_RETRY = 4;
    localparam int P_READY = 5;
    localparam int P_FAIL  = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       cal_done;
    logic       cal_fail;
    logic       qdr_doffn;
    logic       ctrl_reset;
    logic       cal_start;
    logic       phy_ready;
    logic       init_fail;
    logic [1:0] retry_count;

    int checks = 0;
    int errors = 0;

    int m_phase = P_IDLE;
    int m_age   = 0;
    int m_rc    = 0;
    bit m_sync1 = 1'b0;
    bit m_sync2 = 1'b0;

    int cyc        = 0;
    int dut_starts = 0;
    int doffn_rise = -1;
    int start_edge = -1;
    int ready_edge = -1;

    always #5 clk = ~clk;

    qdr_init_sequencer #(
        .PLL_STABLE (PS),
        .DOFF_WAIT  (DW),
        .CAL_TIMEOUT(CT),
        .MAX_RETRY  (MR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .cal_done   (cal_done),
        .cal_fail   (cal_fail),
        .qdr_doffn  (qdr_doffn),
        .ctrl_reset (ctrl_reset),
        .cal_start  (cal_start),
        .phy_ready  (phy_ready),
        .init_fail  (init_fail),
        .retry_count(retry_count)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d cycle=%0d",
                     tag, observed, expected, cyc);
        end
    endtask

    // Reference model: phase plus time-in-phase, advanced once per clock edge.
    task automatic model_step(input bit r, input bit l, input bit d, input bit f);
        int np;
        bit ls;
        if (r) begin
            m_phase = P_IDLE;
            m_age   = 0;
            m_rc    = 0;
            m_sync1 = 1'b0;
            m_sync2 = 1'b0;
            return;
        end
        ls      = m_sync2;
        m_sync2 = m_sync1;
        m_sync1 = l;
        np      = m_phase;
        if (m_phase == P_FAIL) begin
            np = P_FAIL;
        end else if (m_phase == P_IDLE) begin
            if (ls) np = P_LW;
        end else if (!ls) begin
            np   = P_IDLE;
            m_rc = 0;
        end else begin
            case (m_phase)
                P_LW:    if (m_age == PS - 1) np = P_DOFF;
                P_DOFF:  if (m_age == DW - 1) np = P_CAL;
                P_CAL: begin
                    if (f || m_age == CT - 1) begin
                        if (m_rc < MR) begin
                            np   = P_RETRY;
                            m_rc = (m_rc < 3) ? m_rc + 1 : 3;
                        end else begin
                            np = P_FAIL;
                        end
                    end else if (d) begin
                        np = P_READY;
                    end
                end
                P_RETRY: np = P_CAL;
                default: ;
            endcase
        end
        m_age   = (np == m_phase) ? m_age + 1 : 0;
        m_phase = np;
    endtask

    // Drive one cycle of inputs, advance the model and compare every output.
    task automatic applyStimulus(input bit r, input bit l, input bit d, input bit f);
        @(negedge clk);
        reset    = r;
        pll_lock = l;
        cal_done = d;
        cal_fail = f;
        @(posedge clk);
        model_step(r, l, d, f);
        cyc++;
        #1;
        checkOutput("qdr_doffn", int'(qdr_doffn),
                    int'(m_phase == P_DOFF || m_phase == P_CAL ||
                         m_phase == P_RETRY || m_phase == P_READY));
        checkOutput("ctrl_reset", int'(ctrl_reset),
                    int'(!(m_phase == P_CAL || m_phase == P_READY)));
        checkOutput("cal_start", int'(cal_start), int'(m_phase == P_CAL && m_age == 0));
        checkOutput("phy_ready", int'(phy_ready), int'(m_phase == P_READY));
        checkOutput("init_fail", int'(init_fail), int'(m_phase == P_FAIL));
        checkOutput("retry_count", int'(retry_count), m_rc);
        if (cal_start) dut_starts++;
        if (qdr_doffn && doffn_rise < 0) doffn_rise = cyc;
        if (cal_start && start_edge < 0) start_edge = cyc;
        if (phy_ready && ready_edge < 0) ready_edge = cyc;
    endtask

    task automatic run_to(input int ph, input int age, input bit l, input int budget,
                          input string tag);
        int n = 0;
        while (!(m_phase == ph && m_age == age) && n < budget) begin
            applyStimulus(1'b0, l, 1'b0, 1'b0);
            n++;
        end
        if (!(m_phase == ph && m_age == age)) checkOutput({"budget_", tag}, n, -1);
    endtask

    // Hold lock and answer each attempt 'delay' cycles after its start:
    // fail for the first n_fail attempts, then succeed; n_fail<0 never answers.
    task automatic run_cal(input int n_fail, input int delay, input bit both,
                           input int budget, input string tag);
        int n   = 0;
        int att = 0;
        bit d;
        bit f;
        while (m_phase != P_READY && m_phase != P_FAIL && n < budget) begin
            d = 1'b0;
            f = 1'b0;
            if (m_phase == P_CAL && m_age == delay && n_fail >= 0) begin
                if (att < n_fail) begin
                    f = 1'b1;
                    d = both;
                end else begin
                    d = 1'b1;
                end
                att++;
            end
            applyStimulus(1'b0, 1'b1, d, f);
            n++;
        end
        if (m_phase != P_READY && m_phase != P_FAIL) checkOutput({"budget_", tag}, n, -1);
    endtask

    task automatic do_reset();
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int low_left;
        bit r;
        bit l;
        bit d;
        bit f;
        reset    = 1'b1;
        pll_lock = 1'b0;
        cal_done = 1'b0;
        cal_fail = 1'b0;

        $display("[TB] reset values");
        do_reset();
        checkOutput("rst_ctrl_reset", int'(ctrl_reset), 1);
        checkOutput("rst_doffn", int'(qdr_doffn), 0);

        $display("[TB] nominal bring-up");
        cyc        = 0;
        doffn_rise = -1;
        start_edge = -1;
        ready_edge = -1;
        run_cal(0, 3, 1'b0, 200, "nominal");
        checkOutput("nom_doffn_rise", doffn_rise, 3 + PS);
        checkOutput("nom_cal_start", start_edge, 3 + PS + DW);
        checkOutput("nom_ready_edge", ready_edge, 3 + PS + DW + 4);
        checkOutput("nom_ctrl_reset", int'(ctrl_reset), 0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] lock loss in READY");
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("loss_phy_ready", int'(phy_ready), 0);
        checkOutput("loss_doffn", int'(qdr_doffn), 0);
        checkOutput("loss_ctrl_reset", int'(ctrl_reset), 1);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] relock with three failed attempts");
        dut_starts = 0;
        run_cal(3, 0, 1'b0, 400, "retry");
        checkOutput("retry_starts", dut_starts, 1 + MR);
        checkOutput("retry_count_final", int'(retry_count), 3);
        checkOutput("retry_phy_ready", int'(phy_ready), 1);
        checkOutput("retry_init_fail", int'(init_fail), 0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("loss_retry_clear", int'(retry_count), 0);

        $display("[TB] calibration exhaustion");
        do_reset();
        dut_starts = 0;
        run_cal(99, 1, 1'b0, 400, "exhaust");
        checkOutput("exh_starts", dut_starts, 1 + MR);
        checkOutput("exh_init_fail", int'(init_fail), 1);
        checkOutput("exh_doffn", int'(qdr_doffn), 0);
        checkOutput("exh_ctrl_reset", int'(ctrl_reset), 1);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("exh_sticky", int'(init_fail), 1);

        $display("[TB] calibration timeout");
        do_reset();
        dut_starts = 0;
        cyc        = 0;
        run_cal(-1, 0, 1'b0, 400, "timeout");
        checkOutput("tmo_starts", dut_starts, 1 + MR);
        checkOutput("tmo_fail_edge", cyc, 3 + PS + DW + (1 + MR) * CT + MR);
        checkOutput("tmo_init_fail", int'(init_fail), 1);

        $display("[TB] lock glitch in LOCK_WAIT");
        do_reset();
        run_to(P_LW, 2, 1'b1, 50, "glitch");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        run_cal(0, 2, 1'b0, 200, "glitch_cal");
        checkOutput("glitch_ready", int'(phy_ready), 1);

        $display("[TB] done and fail together");
        do_reset();
        run_cal(1, 1, 1'b1, 300, "collide");
        checkOutput("collide_retry", int'(retry_count), 1);
        checkOutput("collide_ready", int'(phy_ready), 1);

        $display("[TB] reset during calibration");
        do_reset();
        run_to(P_CAL, 2, 1'b1, 100, "midcal");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("midcal_doffn", int'(qdr_doffn), 0);
        checkOutput("midcal_ctrl_reset", int'(ctrl_reset), 1);
        checkOutput("midcal_cal_start", int'(cal_start), 0);

        $display("[TB] randomized run");
        low_left = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            if (low_left > 0) begin
                l = 1'b0;
                low_left--;
            end else if ($urandom_range(0, 79) == 0) begin
                l        = 1'b0;
                low_left = int'($urandom_range(0, 4));
            end else begin
                l = 1'b1;
            end
            d = ($urandom_range(0, 9) == 0);
            f = ($urandom_range(0, 11) == 0);
            applyStimulus(r, l, d, f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
